// File: rtl/lr_car_sensor.sv
// Local-road vehicle detector conditioning: two-flop synchronizer, debounce FSM,
// request latch held until green, plus arrival pulse/tally and wait-time counter.
module lr_car_sensor #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int CNT_W        = 8,
    parameter int WAIT_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sensor_raw,
    input  logic [2:0]        lr_light,
    output logic              lr_has_car,
    output logic              car_arrive,
    output logic [CNT_W-1:0]  car_total,
    output logic [WAIT_W-1:0] wait_cnt
);

    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_CONF_HI = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;
    localparam logic [1:0] ST_CONF_LO = 2'd3;
    localparam logic [3:0] CNT_LAST   = 4'(DEBOUNCE_CYC - 1);
    localparam logic [2:0] LIGHT_GRN  = 3'b100;

    logic              r_s1_p0;
    logic              r_s_p1;
    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_has_car;
    logic              r_arrive;
    logic [CNT_W-1:0]  r_total;
    logic [WAIT_W-1:0] r_wait;

    logic [1:0]        w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_arrive;
    logic              w_green;
    logic              w_has_nxt;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (v == {WAIT_W{1'b1}})
            return v;
        return v + {{(WAIT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_arrive    = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (r_s_p1) begin
                    w_state_nxt = ST_CONF_HI;
                    w_cnt_nxt   = 4'd1;
                end
            end
            ST_CONF_HI: begin
                if (!r_s_p1) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = 4'd0;
                    w_arrive    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            ST_HIGH: begin
                if (!r_s_p1) begin
                    w_state_nxt = ST_CONF_LO;
                    w_cnt_nxt   = 4'd1;
                end
            end
            default: begin
                if (r_s_p1) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
        endcase
    end

    // A fresh or ongoing presence (HIGH/CONF_LO next) sets the request; green alone cannot clear it.
    assign w_green   = (lr_light == LIGHT_GRN);
    assign w_has_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_CONF_LO) ||
                       (r_has_car && !w_green);

    // Stage p0/p1: synchronizer for the asynchronous detector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_p0 <= 1'b0;
            r_s_p1  <= 1'b0;
        end else begin
            r_s1_p0 <= sensor_raw;
            r_s_p1  <= r_s1_p0;
        end
    end

    // Stage p2: debounce state, request latch and monitoring counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_LOW;
            r_cnt     <= 4'd0;
            r_has_car <= 1'b0;
            r_arrive  <= 1'b0;
            r_total   <= '0;
            r_wait    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_has_car <= w_has_nxt;
            r_arrive  <= w_arrive;
            if (w_arrive)
                r_total <= r_total + {{(CNT_W-1){1'b0}}, 1'b1};
            if (!r_has_car || w_green)
                r_wait <= '0;
            else
                r_wait <= sat_inc(r_wait);
        end
    end

    assign lr_has_car = r_has_car;
    assign car_arrive = r_arrive;
    assign car_total  = r_total;
    assign wait_cnt   = r_wait;

endmodule

// File: tb/tb_lr_car_sensor.sv
// Bench for lr_car_sensor: run-length reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_lr_car_sensor;

    localparam int D  = 4;
    localparam int CW = 8;
    localparam int WW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sensor_raw = 1'b0;
    logic [2:0]    lr_light = 3'b001;
    logic          lr_has_car;
    logic          car_arrive;
    logic [CW-1:0] car_total;
    logic [WW-1:0] wait_cnt;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    lr_car_sensor #(.DEBOUNCE_CYC(D), .CNT_W(CW), .WAIT_W(WW)) dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (sensor_raw),
        .lr_light   (lr_light),
        .lr_has_car (lr_has_car),
        .car_arrive (car_arrive),
        .car_total  (car_total),
        .wait_cnt   (wait_cnt)
    );

    always #5 clk = ~clk;

    // Reference: the debounced level flips once the last D synchronized samples all disagree with it.
    logic          m_d1, m_d2, m_last, m_level, m_has, m_arrive;
    int            m_run;
    logic [CW-1:0] m_total;
    int            m_wait;

    always @(posedge clk or posedge rst) begin
        logic smp, old_has, green;
        if (rst) begin
            m_d1 = 0; m_d2 = 0; m_last = 0; m_level = 0; m_has = 0; m_arrive = 0;
            m_run = 0; m_total = 0; m_wait = 0;
        end else begin
            smp = m_d2;
            m_d2 = m_d1;
            m_d1 = sensor_raw;
            old_has = m_has;
            green = (lr_light == 3'b100);
            if (smp == m_last) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_last = smp;
            m_arrive = 0;
            if (m_run >= D && smp != m_level) begin
                m_level = smp;
                if (smp) begin
                    m_arrive = 1;
                    m_total = m_total + 1'b1;
                end
            end
            m_has = m_level || (old_has && !green);
            if (!old_has || green) m_wait = 0;
            else if (m_wait < (1 << WW) - 1) m_wait = m_wait + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_has", 32'(lr_has_car), 32'(m_has));
            chk("model_arrive", 32'(car_arrive), 32'(m_arrive));
            chk("model_total", 32'(car_total), 32'(m_total));
            chk("model_wait", 32'(wait_cnt), m_wait);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_has"}, 32'(lr_has_car), 0);
        chk({nm, "_arrive"}, 32'(car_arrive), 0);
        chk({nm, "_total"}, 32'(car_total), 0);
        chk({nm, "_wait"}, 32'(wait_cnt), 0);
    endtask

    logic [2:0] lights [5];

    initial begin
        lights[0] = 3'b100; lights[1] = 3'b010; lights[2] = 3'b001;
        lights[3] = 3'b000; lights[4] = 3'b111;

        step();
        cmp_en = 1'b1;
        chk_zero("reset");
        step();
        rst = 1'b0;
        repeat (3) step();

        // Clean arrival under red: accepted five edges after raw is first sampled high.
        sensor_raw = 1'b1;
        step();
        repeat (4) step();
        chk("pre_arrive", 32'(car_arrive), 0);
        chk("pre_has", 32'(lr_has_car), 0);
        step();
        chk("arrive_pulse", 32'(car_arrive), 1);
        chk("arrive_total", 32'(car_total), 1);
        chk("arrive_has", 32'(lr_has_car), 1);
        chk("arrive_wait", 32'(wait_cnt), 0);
        chk("model_pin_total", 32'(m_total), 1);
        step();
        chk("pulse_end", 32'(car_arrive), 0);
        chk("wait_1", 32'(wait_cnt), 1);
        step();
        chk("wait_2", 32'(wait_cnt), 2);

        // Car leaves under red, request holds until green is sampled.
        repeat (14) step();
        sensor_raw = 1'b0;
        repeat (10) step();
        chk("hold_has", 32'(lr_has_car), 1);
        lr_light = 3'b100;
        step();
        chk("green_has", 32'(lr_has_car), 0);
        chk("green_wait", 32'(wait_cnt), 0);
        lr_light = 3'b001;

        // 1- and 3-sample glitches are rejected.
        sensor_raw = 1'b1;
        step();
        sensor_raw = 1'b0;
        repeat (10) step();
        sensor_raw = 1'b1;
        repeat (3) step();
        sensor_raw = 1'b0;
        repeat (10) step();
        chk("glitch_total", 32'(car_total), 1);
        chk("glitch_has", 32'(lr_has_car), 0);
        chk("glitch_arrive", 32'(car_arrive), 0);

        // Arrival on the same edge green is sampled: set wins.
        sensor_raw = 1'b1;
        step();
        repeat (4) step();
        lr_light = 3'b100;
        step();
        chk("setwin_has", 32'(lr_has_car), 1);
        chk("setwin_arrive", 32'(car_arrive), 1);
        chk("setwin_total", 32'(car_total), 2);
        repeat (5) step();
        sensor_raw = 1'b0;
        step();
        repeat (4) step();
        chk("green_fall_hold", 32'(lr_has_car), 1);
        step();
        chk("green_fall_clear", 32'(lr_has_car), 0);
        lr_light = 3'b001;
        repeat (3) step();

        // Reset while confirming a rising edge.
        sensor_raw = 1'b1;
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk_zero("rst_confhi");
        sensor_raw = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (8) step();
        chk_zero("rst_confhi_after");

        // Reset while a request is latched.
        sensor_raw = 1'b1;
        repeat (8) step();
        sensor_raw = 1'b0;
        repeat (8) step();
        chk("latched_has", 32'(lr_has_car), 1);
        chk("latched_total", 32'(car_total), 1);
        rst = 1'b1;
        #1;
        chk_zero("rst_latched");
        step();
        rst = 1'b0;
        repeat (5) step();
        chk_zero("rst_latched_after");

        // 2^CNT_W clean arrivals wrap the tally back to zero.
        for (int i = 0; i < 256; i++) begin
            lr_light = lights[$urandom_range(0, 4)];
            sensor_raw = 1'b1;
            repeat ($urandom_range(5, 9)) step();
            sensor_raw = 1'b0;
            repeat ($urandom_range(5, 9)) step();
        end
        repeat (4) step();
        chk("wrap_total", 32'(car_total), 0);
        chk("model_pin_wrap", 32'(m_total), 0);

        // Long wait under red saturates.
        lr_light = 3'b001;
        sensor_raw = 1'b1;
        repeat (1100) step();
        chk("wait_sat", 32'(wait_cnt), 1023);
        chk("model_pin_sat", 32'(m_wait), 1023);
        sensor_raw = 1'b0;
        lr_light = 3'b100;
        repeat (8) step();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) sensor_raw = ~sensor_raw;
            if ($urandom_range(0, 19) == 0) lr_light = lights[$urandom_range(0, 4)];
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
